// File: rtl/joypad_ctrl.sv
// Joypad controller: per-key press-pulse hold timers plus the memory-mapped P1 select/read register.
// Latency: key_held 1 cycle after press, data_out 1 cycle after read, irq_joypad 1 cycle after a nibble bit falls.
// Backpressure: none; presses, reads and writes are accepted every cycle.
module joypad_ctrl #(
    parameter int HOLD_CYCLES = 1000000,
    parameter int HOLD_WIDTH  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  key_pressed,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  data_out,
    output logic        irq_joypad,
    output logic [7:0]  key_held
);

    typedef enum logic {
        KEY_IDLE = 1'b0,
        KEY_HELD = 1'b1
    } key_state_t;

    localparam logic [15:0]           P1_ADDR   = 16'hFF00;
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1);

    logic [1:0] sel;
    logic [3:0] nibble;
    logic [3:0] prev_nibble;
    logic [7:0] p1_value;
    logic       p1_hit;
    logic       unused_data;

    // One independent hold timer per key; a fresh press always restarts the hold.
    for (genvar i = 0; i < 8; i++) begin : g_key
        key_state_t            state;
        logic [HOLD_WIDTH-1:0] hold_cnt;

        always_ff @(posedge clock) begin
            if (reset) begin
                state    <= KEY_IDLE;
                hold_cnt <= '0;
            end else if (key_pressed[i]) begin
                state    <= KEY_HELD;
                hold_cnt <= '0;
            end else if (state == KEY_HELD) begin
                if (hold_cnt == HOLD_LAST) begin
                    state    <= KEY_IDLE;
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                end
            end
        end

        assign key_held[i] = (state == KEY_HELD);
    end

    assign p1_hit      = (addr == P1_ADDR);
    assign nibble      = ~(({4{~sel[0]}} & key_held[3:0]) | ({4{~sel[1]}} & key_held[7:4]));
    assign p1_value    = {2'b11, sel, nibble};
    assign unused_data = ^{data_in[7:6], data_in[3:0]};

    // Reads sample p1_value before the sel update, so a same-cycle write is not visible yet.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel         <= 2'b11;
            prev_nibble <= 4'hF;
            data_out    <= 8'h00;
            irq_joypad  <= 1'b0;
        end else begin
            if (we && p1_hit) begin
                sel <= data_in[5:4];
            end
            data_out    <= (re && p1_hit) ? p1_value : 8'h00;
            prev_nibble <= nibble;
            irq_joypad  <= |(prev_nibble & ~nibble);
        end
    end

endmodule

// File: tb/tb_joypad_ctrl.sv
// Testbench for joypad_ctrl with HOLD_CYCLES=4: table of per-cycle vectors plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_joypad_ctrl;

    localparam logic [15:0] A_P1  = 16'hFF00;
    localparam logic [15:0] A_OFF = 16'hFF01;
    localparam logic [15:0] A_NO  = 16'h0000;

    logic        clock;
    logic        reset;
    logic [7:0]  key_pressed;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        we;
    logic        re;
    logic [7:0]  data_out;
    logic        irq_joypad;
    logic [7:0]  key_held;

    joypad_ctrl #(.HOLD_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_pressed (key_pressed),
        .addr        (addr),
        .data_in     (data_in),
        .we          (we),
        .re          (re),
        .data_out    (data_out),
        .irq_joypad  (irq_joypad),
        .key_held    (key_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [7:0]  kp;
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        logic        r;
        logic [7:0]  e_held;
        logic        e_irq;
        logic [7:0]  e_dout;
    } vec_t;

    typedef struct {
        logic [7:0] held;
        logic       irq;
        logic [7:0] dout;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   step_no = 0;

    function automatic vec_t v(input logic rst, input logic [7:0] kp, input logic [15:0] a,
                               input logic [7:0] d, input logic w, input logic r,
                               input logic [7:0] e_held, input logic e_irq, input logic [7:0] e_dout);
        vec_t t;
        t.rst = rst; t.kp = kp; t.a = a; t.d = d; t.w = w; t.r = r;
        t.e_held = e_held; t.e_irq = e_irq; t.e_dout = e_dout;
        return t;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty step %0d: got no expectation, required one", step_no);
            return;
        end
        e = sb.pop_front();
        total++;
        if (key_held === e.held) passed++;
        else $display("FAIL key_held step %0d: got %h, required %h", e.tag, key_held, e.held);
        total++;
        if (irq_joypad === e.irq) passed++;
        else $display("FAIL irq_joypad step %0d: got %b, required %b", e.tag, irq_joypad, e.irq);
        total++;
        if (data_out === e.dout) passed++;
        else $display("FAIL data_out step %0d: got %h, required %h", e.tag, data_out, e.dout);
    endtask

    // Drive one cycle of inputs, queue what the outputs must be after the edge, then compare.
    task automatic step(input vec_t t);
        exp_t e;
        @(negedge clock);
        reset       = t.rst;
        key_pressed = t.kp;
        addr        = t.a;
        data_in     = t.d;
        we          = t.w;
        re          = t.r;
        e.held = t.e_held;
        e.irq  = t.e_irq;
        e.dout = t.e_dout;
        e.tag  = step_no;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_out();
        step_no++;
    endtask

    task automatic idle(input logic [7:0] e_held, input logic e_irq);
        step(v(1'b0, 8'h00, A_NO, 8'h00, 1'b0, 1'b0, e_held, e_irq, 8'h00));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; key_pressed = 8'h00; addr = A_NO; data_in = 8'h00; we = 1'b0; re = 1'b0;

        //             rst  kp     addr   din    we    re    held   irq   dout
        vecs.push_back(v(1, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00)); // reset
        vecs.push_back(v(0, 8'h00, A_P1,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF)); // read after reset
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_P1,  8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00)); // sel = buttons
        vecs.push_back(v(0, 8'h10, A_NO,  8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00)); // press A
        vecs.push_back(v(0, 8'h00, A_P1,  8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 8'hDE));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00)); // hold expired
        vecs.push_back(v(0, 8'h00, A_P1,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hDF));
        vecs.push_back(v(0, 8'h00, A_P1,  8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00)); // sel = directions
        vecs.push_back(v(0, 8'h01, A_NO,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00)); // right at N
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00));
        vecs.push_back(v(0, 8'h01, A_NO,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00)); // right at N+2
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_P1,  8'h30, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00)); // sel = none
        vecs.push_back(v(0, 8'h08, A_NO,  8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 8'h00)); // press down
        vecs.push_back(v(0, 8'h00, A_P1,  8'h20, 1'b1, 1'b0, 8'h08, 1'b0, 8'h00)); // select directions
        vecs.push_back(v(0, 8'h00, A_P1,  8'h30, 1'b1, 1'b0, 8'h08, 1'b1, 8'h00)); // deselect
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_P1,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00)); // sel = both
        vecs.push_back(v(0, 8'h82, A_NO,  8'h00, 1'b0, 1'b0, 8'h82, 1'b0, 8'h00)); // start + left
        vecs.push_back(v(0, 8'h00, A_P1,  8'h00, 1'b0, 1'b1, 8'h82, 1'b1, 8'hC5));
        vecs.push_back(v(0, 8'h00, A_P1,  8'h30, 1'b1, 1'b1, 8'h82, 1'b0, 8'hC5)); // read+write
        vecs.push_back(v(0, 8'h00, A_P1,  8'h00, 1'b0, 1'b1, 8'h82, 1'b0, 8'hFF));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_OFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00)); // miss write
        vecs.push_back(v(0, 8'h00, A_P1,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF));
        vecs.push_back(v(0, 8'h00, A_OFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00)); // miss read
        vecs.push_back(v(0, 8'h00, A_P1,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h01, A_NO,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00));
        vecs.push_back(v(1, 8'h02, A_P1,  8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00)); // reset mid-hold
        vecs.push_back(v(0, 8'h00, A_P1,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));
        vecs.push_back(v(0, 8'h00, A_NO,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00));

        foreach (vecs[i]) step(vecs[i]);

        // Press landing on the expiry cycle must extend the hold by a full period.
        step(v(0, 8'h04, A_NO, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 8'h00));
        for (int i = 0; i < 3; i++) idle(8'h04, 1'b0);
        step(v(0, 8'h04, A_NO, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 8'h00));
        for (int i = 0; i < 3; i++) idle(8'h04, 1'b0);
        idle(8'h00, 1'b0);

        // Two nibble bits falling together give a single one-cycle interrupt.
        step(v(0, 8'h00, A_P1, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00));
        step(v(0, 8'h03, A_NO, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 8'h00));
        idle(8'h03, 1'b1);
        idle(8'h03, 1'b0);
        step(v(0, 8'h00, A_P1, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 8'hEC));
        idle(8'h00, 1'b0);
        idle(8'h00, 1'b0);

        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
